// File: rtl/fast_pkg.sv
// Shared constants for the FAST-9 pipeline: window geometry and the radius-3
// Bresenham circle ordering used by every stage downstream of the circle generator.
package fast_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned CIRCLE_R   = 3;
    localparam int unsigned WIN        = 7;
    localparam int unsigned NUM_CIRCLE = 16;
    localparam int unsigned LB_LINES   = WIN - 1;
    localparam int unsigned LB_W       = LB_LINES * PIX_W;
    localparam int unsigned CIRCLE_W   = NUM_CIRCLE * PIX_W;

    // Clockwise from top, y grows downward; consumers rely on this exact order.
    localparam int DX [NUM_CIRCLE] = '{ 0,  1,  2,  3,  3,  3,  2,  1,
                                        0, -1, -2, -3, -3, -3, -2, -1};
    localparam int DY [NUM_CIRCLE] = '{-3, -3, -2, -1,  0,  1,  2,  3,
                                        3,  3,  2,  1,  0, -1, -2, -3};

    typedef logic [PIX_W-1:0] pixel_t;

    // Indexed [row][col]; row 0 is the oldest line, col 0 the oldest column.
    typedef logic [WIN-1:0][WIN-1:0][PIX_W-1:0] window_t;

    typedef struct packed {
        logic [CIRCLE_W-1:0] circle;
        pixel_t              center;
    } circle_pl_t;

    function automatic int unsigned circle_row(input int unsigned k);
        return int'(CIRCLE_R) + DY[k];
    endfunction

    function automatic int unsigned circle_col(input int unsigned k);
        return int'(CIRCLE_R) + DX[k];
    endfunction

endpackage

// File: rtl/fast_line_buffer.sv
// Single-port line RAM with combinational read, so the old word is seen in the
// same cycle it is overwritten (read-before-write). Contents are not reset.
module fast_line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned W     = 48,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata_c
);

    logic [W-1:0] mem_q [DEPTH];

    assign o_rdata_c = mem_q[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/fast_circle_gen.sv
// Raster-stream front end for FAST-9: six line buffers plus a 7x7 window, emitting
// the 16-pixel radius-3 circle and centre for every pixel at least 3 from each edge.
module fast_circle_gen
    import fast_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    localparam int unsigned CW   = $clog2(IMG_W),
    localparam int unsigned RW   = $clog2(IMG_H)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic                i_sof,
    input  logic [PIX_W-1:0]    i_pixel,
    output logic                o_valid,
    output logic [CIRCLE_W-1:0] o_circle,
    output logic [PIX_W-1:0]    o_center,
    output logic [CW-1:0]       o_col,
    output logic [RW-1:0]       o_row
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    window_t       win_q, win_d;
    logic          valid_q, valid_d;
    circle_pl_t    pl_q, pl_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic [RW-1:0] out_row_q, out_row_d;

    logic [CW-1:0] pix_col;
    logic [RW-1:0] pix_row;
    logic          emit;
    logic [LB_W-1:0] lb_rdata;
    logic [LB_W-1:0] lb_wdata;

    // Position of the pixel on the input this cycle; sof forces it to the origin.
    assign pix_col = i_sof ? '0 : col_q;
    assign pix_row = i_sof ? '0 : row_q;
    assign emit    = i_valid && (pix_col >= CW'(WIN - 1)) && (pix_row >= RW'(WIN - 1));

    // All six lines share one address, so they live in one 48-bit wide RAM; lb0 is the low byte.
    assign lb_wdata = {lb_rdata[LB_W-PIX_W-1:0], i_pixel};

    fast_line_buffer #(
        .DEPTH (IMG_W),
        .W     (LB_W)
    ) u_line_buffer (
        .i_clk     (i_clk),
        .i_we      (i_valid),
        .i_addr    (pix_col),
        .i_wdata   (lb_wdata),
        .o_rdata_c (lb_rdata)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_valid) begin
            if (pix_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (pix_row == RW'(IMG_H - 1)) ? '0 : pix_row + RW'(1);
            end else begin
                col_d = pix_col + CW'(1);
                row_d = pix_row;
            end
        end
    end

    // Shift left one column; new column is lb5 (oldest line) at the top down to the live pixel.
    always_comb begin
        win_d = win_q;
        if (i_valid) begin
            for (int y = 0; y < int'(WIN); y++) begin
                for (int x = 0; x < int'(WIN) - 1; x++) begin
                    win_d[y][x] = win_q[y][x+1];
                end
            end
            for (int y = 0; y < int'(LB_LINES); y++) begin
                win_d[y][WIN-1] = lb_rdata[(int'(LB_LINES) - 1 - y)*int'(PIX_W) +: PIX_W];
            end
            win_d[WIN-1][WIN-1] = i_pixel;
        end
    end

    // Circle is taken from the post-shift window so the output lands one cycle after accept.
    always_comb begin
        valid_d   = emit;
        pl_d      = pl_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        if (emit) begin
            pl_d.center = win_d[CIRCLE_R][CIRCLE_R];
            for (int unsigned k = 0; k < NUM_CIRCLE; k++) begin
                pl_d.circle[k*PIX_W +: PIX_W] = win_d[circle_row(k)][circle_col(k)];
            end
            out_col_d = pix_col - CW'(CIRCLE_R);
            out_row_d = pix_row - RW'(CIRCLE_R);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            valid_q   <= 1'b0;
            pl_q      <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            valid_q   <= valid_d;
            pl_q      <= pl_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_circle = pl_q.circle;
    assign o_center = pl_q.center;
    assign o_col    = out_col_q;
    assign o_row    = out_row_q;

endmodule

// File: tb/tb_fast_circle_gen.sv
// Scoreboard bench for fast_circle_gen on a 16x10 frame: an image model predicts every
// circle/centre output, a monitor checks them, and directed checks pin the key values.
module tb_fast_circle_gen;

    localparam int W  = 16;
    localparam int H  = 10;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_sof = 1'b0;
    logic [7:0]   i_pixel = 8'h00;
    logic         o_valid;
    logic [127:0] o_circle;
    logic [7:0]   o_center;
    logic [CW-1:0] o_col;
    logic [RW-1:0] o_row;

    fast_circle_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_sof    (i_sof),
        .i_pixel  (i_pixel),
        .o_valid  (o_valid),
        .o_circle (o_circle),
        .o_center (o_center),
        .o_col    (o_col),
        .o_row    (o_row)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int           col;
        int           row;
        logic [7:0]   center;
        logic [127:0] circle;
    } out_t;

    int ODX [16] = '{ 0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3, -3, -3, -2, -1};
    int ODY [16] = '{-3, -3, -2, -1,  0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3};

    out_t       sbq [$];
    out_t       got_log [$];
    out_t       ref_log [$];
    logic [7:0] img [H][W];
    int         bc = 0;
    int         br = 0;
    bit         drv_emit = 1'b0;
    bit         exp_valid = 1'b0;
    bit         mon_en = 1'b0;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One stimulus cycle; on accept, update the image model and predict any output.
    task automatic drive(input bit v, input bit s, input logic [7:0] p);
        out_t e;
        @(negedge i_clk);
        i_valid  = v;
        i_sof    = s;
        i_pixel  = p;
        drv_emit = 1'b0;
        if (v) begin
            if (s) begin
                bc = 0;
                br = 0;
            end
            img[br][bc] = p;
            if (bc >= 6 && br >= 6) begin
                e.col    = bc - 3;
                e.row    = br - 3;
                e.center = img[br-3][bc-3];
                e.circle = '0;
                for (int k = 0; k < 16; k++) begin
                    e.circle[8*k +: 8] = img[br-3+ODY[k]][bc-3+ODX[k]];
                end
                sbq.push_back(e);
                drv_emit = 1'b1;
            end
            if (bc == W - 1) begin
                bc = 0;
                br = (br == H - 1) ? 0 : br + 1;
            end else begin
                bc = bc + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_pixel(input int r, input int c, input logic [7:0] off,
                              input int gap_pct, input bit use_sof);
        int n = 0;
        while (gap_pct > 0 && n < 4 && $urandom_range(0, 99) < gap_pct) begin
            drive(1'b0, 1'b0, 8'h00);
            n++;
        end
        drive(1'b1, use_sof && r == 0 && c == 0, 8'(r * 16 + c) + off);
    endtask

    task automatic send_frame(input logic [7:0] off, input int gap_pct, input bit use_sof);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pixel(r, c, off, gap_pct, use_sof);
            end
        end
    endtask

    always @(posedge i_clk) begin
        exp_valid <= i_rst_n ? drv_emit : 1'b0;
    end

    // Monitor: per-cycle valid check plus scoreboard pop on every output.
    always @(negedge i_clk) begin
        out_t e;
        out_t g;
        if (mon_en) begin
            check("o_valid", 128'(o_valid), 128'(exp_valid));
            if (o_valid === 1'b1) begin
                g.col    = int'(o_col);
                g.row    = int'(o_row);
                g.center = o_center;
                g.circle = o_circle;
                got_log.push_back(g);
                tests++;
                if (g.col < 3 || g.col > 12) begin
                    fails++;
                    $display("FAIL col_range: got %0d expected 3..12", g.col);
                end
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got col %0d row %0d expected none", g.col, g.row);
                end else begin
                    e = sbq.pop_front();
                    check("sb_col", 128'(g.col), 128'(e.col));
                    check("sb_row", 128'(g.row), 128'(e.row));
                    check("sb_center", 128'(g.center), 128'(e.center));
                    check("sb_circle", g.circle, e.circle);
                end
            end
        end
    end

    task automatic check_same_as_ref(input string name);
        check({name, "_count"}, 128'(got_log.size()), 128'(ref_log.size()));
        if (got_log.size() == ref_log.size()) begin
            for (int i = 0; i < got_log.size(); i++) begin
                check({name, "_pos"}, 128'({got_log[i].col, got_log[i].row}),
                      128'({ref_log[i].col, ref_log[i].row}));
                check({name, "_data"}, {got_log[i].circle[119:0], got_log[i].center},
                      {ref_log[i].circle[119:0], ref_log[i].center});
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_circle", o_circle, 128'(0));
        check("rst_center", 128'(o_center), 128'(0));
        check("rst_col", 128'(o_col), 128'(0));
        check("rst_row", 128'(o_row), 128'(0));
        mon_en = 1'b1;

        // Continuous frame with hand-computed key outputs.
        got_log.delete();
        send_frame(8'h00, 0, 1'b1);
        idle(3);
        check("f1_count", 128'(got_log.size()), 128'(40));
        if (got_log.size() == 40) begin
            check("f1_first_center", 128'(got_log[0].center), 128'(8'h33));
            check("f1_first_col", 128'(got_log[0].col), 128'(3));
            check("f1_first_row", 128'(got_log[0].row), 128'(3));
            check("f1_k0", 128'(got_log[0].circle[7:0]), 128'(8'h03));
            check("f1_k4", 128'(got_log[0].circle[39:32]), 128'(8'h36));
            check("f1_k8", 128'(got_log[0].circle[71:64]), 128'(8'h63));
            check("f1_k12", 128'(got_log[0].circle[103:96]), 128'(8'h30));
            check("f1_last_col", 128'(got_log[39].col), 128'(12));
            check("f1_last_row", 128'(got_log[39].row), 128'(6));
            check("f1_last_center", 128'(got_log[39].center), 128'(8'h6C));
        end
        ref_log = got_log;

        // Same frame with random valid gaps must give an identical output sequence.
        got_log.delete();
        send_frame(8'h00, 50, 1'b1);
        idle(3);
        check_same_as_ref("gap");

        // Two back-to-back frames, second offset by 0x80.
        got_log.delete();
        send_frame(8'h00, 0, 1'b1);
        send_frame(8'h80, 0, 1'b1);
        idle(3);
        check("ff_count", 128'(got_log.size()), 128'(80));
        if (got_log.size() == 80) begin
            check("ff2_first_center", 128'(got_log[40].center), 128'(8'hB3));
            check("ff2_first_pos", 128'({got_log[40].col, got_log[40].row}), 128'({32'd3, 32'd3}));
            check("ff2_k0", 128'(got_log[40].circle[7:0]), 128'(8'h83));
        end

        // sof arrives where pixel (5,7) would be; old frame emitted only row 6 (10 outputs).
        got_log.delete();
        for (int i = 0; i < 7 * W + 5; i++) begin
            send_pixel(i / W, i % W, 8'h00, 0, 1'b1);
        end
        send_frame(8'h40, 0, 1'b1);
        idle(3);
        check("sof_count", 128'(got_log.size()), 128'(50));
        if (got_log.size() == 50) begin
            check("sof_pre_last_pos", 128'({got_log[9].col, got_log[9].row}), 128'({32'd12, 32'd3}));
            check("sof_first_pos", 128'({got_log[10].col, got_log[10].row}), 128'({32'd3, 32'd3}));
            check("sof_first_center", 128'(got_log[10].center), 128'(8'h73));
        end

        // Reset after 50 pixels; the next frame starts at (0,0) even without sof.
        for (int i = 0; i < 50; i++) begin
            send_pixel(i / W, i % W, 8'h00, 0, 1'b1);
        end
        @(negedge i_clk);
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_sof    = 1'b0;
        drv_emit = 1'b0;
        bc = 0;
        br = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check("rst2_valid", 128'(o_valid), 128'(0));
        check("rst2_circle", o_circle, 128'(0));
        check("rst2_center", 128'(o_center), 128'(0));
        got_log.delete();
        send_frame(8'h00, 0, 1'b0);
        idle(3);
        check_same_as_ref("rst2");

        check("sb_drained", 128'(sbq.size()), 128'(0));
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
